snina_and_scheduler: RTL
========================

Name: snina_and_scheduler

Overview:
- Shares one pipelined two-share, duplicated-copy SNINA AND gadget between NUM_REQ requesters.
- Round-robin arbitration; at most one issue per cycle; one fresh random bit bound to each issue.
- Returns results tagged to the owning requester and checks the gadget's per-share consistency flags.
- On any fault: stops issuing, suppresses in-flight results and locks until reset.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- K, 1, redundancy order; every share is K+1 bits (identical copies).
- LAT, 2, gadget latency from operand capture to c/errorFlag outputs.
- FLAG_OK, 1, gadget errorFlag value meaning "copies consistent".

Ports:
- clk  in  1  clock; all flops rising-edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_ready  out  NUM_REQ  one-hot grant; handshake = valid&ready.
- req_a_0, req_a_1, req_b_0, req_b_1  in  NUM_REQ*(K+1) each  packed operand shares, requester i at slice i.
- rnd  in  1  fresh randomness.
- rnd_valid  in  1  rnd usable this cycle.
- rnd_ready  out  1  rnd consumed (equals "an issue happens").
- g_a_0, g_a_1, g_b_0, g_b_1  out  K+1 each  operands to gadget.
- g_r  out  1  randomness to gadget.
- g_c_0, g_c_1  in  K+1 each  gadget result shares.
- g_flag_0, g_flag_1  in  1 each  gadget consistency flags.
- rsp_valid  out  1  result valid; no backpressure.
- rsp_id  out  clog2(NUM_REQ)  owning requester.
- rsp_c_0, rsp_c_1  out  K+1 each  result shares.
- rsp_fault  out  1  result invalid because of a detected fault.
- alarm  out  1  sticky fault indicator.

Behaviour:
- Reset values: req_ready=0, rnd_ready=0, rsp_valid=0, rsp_id=0, rsp_c_*=0, rsp_fault=0, alarm=0, all g_* outputs=0. RR pointer=0, tag pipeline valids=0, state=RUN.
- States:
  - RUN: issue permitted.
  - DRAIN: fault seen, in-flight ops still returning.
  - LOCKED: no activity.
- Issue (RUN only, combinational grant):
  - grant = first requester with req_valid, scanning from the RR pointer upward with wrap, and only when rnd_valid=1.
  - If rnd_valid=0: req_ready=0 and rnd_ready=0.
  - On grant i: req_ready[i]=1, rnd_ready=1, g_* = requester i's shares, g_r=rnd.
  - Pointer moves to i+1 mod NUM_REQ. Pointer holds when there is no grant.
- No grant: all g_* driven 0. Shares are never muxed through from a non-granted requester.
- Tag pipeline: LAT-deep shift register of {valid,id}, filled on issue.
- Response: rsp_* asserted exactly LAT cycles after the handshake cycle (LAT=2 → cycle t+2), driven from g_c_*/g_flag_* and the tag at the pipeline tail.
- Fault check at the tail entry when valid: fault = (g_flag_0!=FLAG_OK) | (g_flag_1!=FLAG_OK).
  - fault=1: rsp_fault=1, rsp_c_0=rsp_c_1=0, alarm set next cycle.
  - RUN→DRAIN. Issue is blocked in the same cycle the fault is seen.
- DRAIN: req_ready=0. Each remaining in-flight op returns with rsp_valid=1, rsp_fault=1 and zeroed shares, whatever its flags. When the pipeline is empty → LOCKED.
- LOCKED: all outputs 0 except alarm=1. Exit only via reset.
- Flags of non-valid pipeline slots are ignored.
- Simultaneous events:
  - Fault at the tail with a new request in the same cycle: no grant.
  - Back-to-back issues every cycle are allowed; throughput is 1 per cycle.
- Reset mid-operation clears the tag pipeline. In-flight results are discarded with no rsp_valid.

Optional Feature:
- SNINA_SCHED_STATS_EN defined:
  - Extra outputs stat_issued (16 bits) and stat_faults (8 bits), saturating counters.
  - stat_issued counts handshakes; stat_faults counts tail entries with fault=1 (including DRAIN returns).
  - Both reset to 0.
- Not defined: the ports and counters are absent.

Decomposition:
- Shared package snina_pkg: state enum {RUN, DRAIN, LOCKED}, the share-width function (K+1), and the id-width function clog2(NUM_REQ).
- One sub-module: snina_rr_arbiter (pointer register plus wrap-around priority grant, gated by an enable input).

Test Plan:
- Single op: requester 2 issues a=1, b=1 as shares a_0=2'b11, a_1=0, b_0=2'b11, b_1=0, with rnd=1, flags=1 → rsp at t+2: rsp_id=2, rsp_fault=0, c_0^c_1=2'b11 passed through.
- All 4 requesters valid continuously with rnd_valid=1 → grants 0,1,2,3,0 on consecutive cycles; one rsp per cycle with ids in the same order.
- rnd_valid=0 for 3 cycles while req_valid=4'b0001 → no req_ready, no rnd_ready, g_*=0; issue happens on the first cycle rnd_valid=1.
- Back-to-back issues at t, t+1; g_flag_0=0 at t+2 → both responses rsp_fault=1 with shares 0; alarm=1 from t+3; req_ready=0 thereafter; LOCKED by t+4.
- Async reset asserted with two ops in flight → no rsp_valid afterwards, alarm=0, first post-reset grant goes to requester 0.
- With SNINA_SCHED_STATS_EN: 5 clean ops then 1 fault → stat_issued=6, stat_faults=1.

Source files
------------

// File: rtl/snina_pkg.sv
// Shared types and width helpers for the SNINA AND-gadget scheduler.
package snina_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    LOCKED = 2'd2
  } sched_state_e;

  // Every share carries K+1 identical copies of the bit.
  function automatic int unsigned share_w(input int unsigned k);
    return k + 1;
  endfunction

  // Requester id width; never narrower than one bit.
  function automatic int unsigned id_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/snina_rr_arbiter.sv
// Round-robin arbiter: wrap-around priority scan starting at the pointer,
// one-hot grant gated by en_i; pointer moves past the winner on each grant.
module snina_rr_arbiter
  import snina_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDW     = id_w(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               gnt_valid_o,
  output logic [IDW-1:0]     gnt_id_o
);

  logic [IDW-1:0] ptr_q, ptr_d;
  int unsigned    idx;

  // First requesting index at or after the pointer, with wrap; next pointer.
  always_comb begin
    gnt_o       = '0;
    gnt_valid_o = 1'b0;
    gnt_id_o    = '0;
    idx         = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr_q) + k) % NUM_REQ;
      if (en_i && !gnt_valid_o && req_i[idx]) begin
        gnt_o[idx]  = 1'b1;
        gnt_valid_o = 1'b1;
        gnt_id_o    = IDW'(idx);
      end
    end
    ptr_d = ptr_q;
    if (gnt_valid_o) begin
      ptr_d = (gnt_id_o == IDW'(NUM_REQ - 1)) ? '0 : gnt_id_o + 1'b1;
    end
  end

  // Pointer register; holds when nothing is granted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/snina_and_scheduler.sv
// Shares one pipelined two-share SNINA AND gadget among NUM_REQ requesters.
// Issues at most one op per cycle, tags results back to the owner and locks
// permanently after any consistency-flag fault until reset.
// Optional statistics counters: define SNINA_SCHED_STATS_EN.
module snina_and_scheduler
  import snina_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned K       = 1,
  parameter  int unsigned LAT     = 2,
  parameter  logic        FLAG_OK = 1'b1,
  localparam int unsigned W       = share_w(K),
  localparam int unsigned IDW     = id_w(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*W-1:0] req_a_0,
  input  logic [NUM_REQ*W-1:0] req_a_1,
  input  logic [NUM_REQ*W-1:0] req_b_0,
  input  logic [NUM_REQ*W-1:0] req_b_1,
  input  logic                 rnd,
  input  logic                 rnd_valid,
  output logic                 rnd_ready,
  output logic [W-1:0]         g_a_0,
  output logic [W-1:0]         g_a_1,
  output logic [W-1:0]         g_b_0,
  output logic [W-1:0]         g_b_1,
  output logic                 g_r,
  input  logic [W-1:0]         g_c_0,
  input  logic [W-1:0]         g_c_1,
  input  logic                 g_flag_0,
  input  logic                 g_flag_1,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [W-1:0]         rsp_c_0,
  output logic [W-1:0]         rsp_c_1,
  output logic                 rsp_fault,
  output logic                 alarm
`ifdef SNINA_SCHED_STATS_EN
  ,
  output logic [15:0]          stat_issued,
  output logic [7:0]           stat_faults
`endif
);

  sched_state_e              state_q;
  logic                      alarm_q;
  logic [LAT-1:0]            tv_q;
  logic [LAT-1:0][IDW-1:0]   tid_q;

  logic                      tail_valid, flags_bad, fault_now, tail_bad;
  logic                      issue_en, upstream_busy;
  logic [NUM_REQ-1:0]        grant;
  logic                      gnt_valid;
  logic [IDW-1:0]            gnt_id;

  assign tail_valid = tv_q[LAT-1];
  assign flags_bad  = (g_flag_0 != FLAG_OK) | (g_flag_1 != FLAG_OK);
  assign fault_now  = tail_valid & flags_bad;
  // Once out of RUN every returning op is reported faulty regardless of flags.
  assign tail_bad   = tail_valid & (flags_bad | (state_q != RUN));
  // A fault arriving at the tail blocks issue in that very cycle.
  assign issue_en   = (state_q == RUN) & rnd_valid & ~fault_now;

  snina_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk_i       (clk),
    .rst_ni      (reset),
    .en_i        (issue_en),
    .req_i       (req_valid),
    .gnt_o       (grant),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
  );

  assign req_ready = grant;
  assign rnd_ready = gnt_valid;
  assign g_r       = rnd & gnt_valid;

  // Gadget operands: only the granted requester's shares, otherwise zero.
  always_comb begin
    g_a_0 = '0;
    g_a_1 = '0;
    g_b_0 = '0;
    g_b_1 = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      g_a_0 = g_a_0 | (req_a_0[i*W +: W] & {W{grant[i]}});
      g_a_1 = g_a_1 | (req_a_1[i*W +: W] & {W{grant[i]}});
      g_b_0 = g_b_0 | (req_b_0[i*W +: W] & {W{grant[i]}});
      g_b_1 = g_b_1 | (req_b_1[i*W +: W] & {W{grant[i]}});
    end
  end

  // Any op still in flight behind the tail entry.
  always_comb begin
    upstream_busy = 1'b0;
    for (int unsigned i = 0; i + 1 < LAT; i++) begin
      upstream_busy = upstream_busy | tv_q[i];
    end
  end

  // Tag pipeline tracking {valid,id} alongside the gadget latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tv_q  <= '0;
      tid_q <= '0;
    end else begin
      tv_q[0]  <= gnt_valid;
      tid_q[0] <= gnt_id;
      for (int unsigned i = 1; i < LAT; i++) begin
        tv_q[i]  <= tv_q[i-1];
        tid_q[i] <= tid_q[i-1];
      end
    end
  end

  // Fault FSM with the sticky alarm registered alongside it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      alarm_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (fault_now) begin
            state_q <= DRAIN;
            alarm_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (!upstream_busy) state_q <= LOCKED;
        end
        LOCKED: state_q <= LOCKED;
        default: begin
          state_q <= LOCKED;
          alarm_q <= 1'b1;
        end
      endcase
    end
  end

  assign alarm     = alarm_q;
  assign rsp_valid = tail_valid;
  assign rsp_id    = tail_valid ? tid_q[LAT-1] : '0;
  assign rsp_fault = tail_bad;
  assign rsp_c_0   = (tail_valid & ~tail_bad) ? g_c_0 : '0;
  assign rsp_c_1   = (tail_valid & ~tail_bad) ? g_c_1 : '0;

`ifdef SNINA_SCHED_STATS_EN
  logic [15:0] stat_issued_q;
  logic [7:0]  stat_faults_q;

  // Saturating counts of handshakes and faulty tail entries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_issued_q <= '0;
      stat_faults_q <= '0;
    end else begin
      if (gnt_valid && (stat_issued_q != '1)) stat_issued_q <= stat_issued_q + 1'b1;
      if (tail_bad && (stat_faults_q != '1))  stat_faults_q <= stat_faults_q + 1'b1;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_faults = stat_faults_q;
`else
  // No statistics counters in this build.
`endif

endmodule
